uart_rx_param: RTL and testbench

- Synthesisable, parametrised UART receiver. Successor to the fixed 8-bit, always-parity simulation receiver model.
- Adds configurable data width, parity mode (none/odd/even) and 1 or 2 stop bits.
- Adds an input synchroniser, 3-sample majority vote per bit, and false-start rejection.
- Delivers each received word through a valid/ready output register with parity, framing and overrun status. Sits between the board RX pin and the ingress logic.

---
 rtl/uart_rx_param.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote per bit,
// false-start rejection and a valid/ready output register with error and overrun status.
module uart_rx_param #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = 1,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BIT_CYC  = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CW       = $clog2(BIT_CYC);

    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] SAMP_A   = CW'(HALF_CYC - 1);
    localparam logic [CW-1:0] SAMP_B   = CW'(HALF_CYC);
    localparam logic [CW-1:0] SAMP_C   = CW'(HALF_CYC + 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY_MODE == 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state_reg, state_next;
    logic                   rx_meta_reg, rx_s_reg;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [3:0]             bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   perr_reg, perr_next;
    logic                   ferr_reg, ferr_next;
    logic                   samp_a_reg, samp_b_reg;
    logic [DATA_BITS-1:0]   dout_reg;
    logic                   dout_valid_reg, perr_out_reg, ferr_out_reg, overrun_reg;

    logic                   maj;
    logic                   maj_point;
    logic                   frame_done;
    logic                   frame_ferr;
    logic                   load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx_in;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // The third vote is the live synchronised line at the decision cycle.
    assign maj = (samp_a_reg & samp_b_reg) | (samp_a_reg & rx_s_reg) | (samp_b_reg & rx_s_reg);
    assign maj_point  = (cnt_reg == SAMP_C) && (state_reg != IDLE) && (state_reg != WAIT_IDLE);
    assign frame_ferr = ferr_reg | ~maj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a_reg <= 1'b0;
            samp_b_reg <= 1'b0;
        end else begin
            if (cnt_reg == SAMP_A) samp_a_reg <= rx_s_reg;
            if (cnt_reg == SAMP_B) samp_b_reg <= rx_s_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= WAIT_IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        perr_next    = perr_reg;
        ferr_next    = ferr_reg;
        frame_done   = 1'b0;
        case (state_reg)
            WAIT_IDLE: begin
                cnt_next = '0;
                if (rx_s_reg) state_next = IDLE;
            end
            IDLE: begin
                cnt_next     = '0;
                bit_cnt_next = '0;
                perr_next    = 1'b0;
                ferr_next    = 1'b0;
                if (!rx_s_reg) state_next = START;
            end
            START: begin
                if (maj_point) state_next = maj ? IDLE : DATA;
            end
            DATA: begin
                if (maj_point) begin
                    shift_next = {maj, shift_reg[DATA_BITS-1:1]};
                    if (bit_cnt_reg == LAST_DATA) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (maj_point) begin
                    perr_next  = (^shift_reg) ^ maj ^ ODD_PAR;
                    state_next = STOP;
                end
            end
            STOP: begin
                // The frame ends at the last stop bit's vote, not at the end of the bit.
                if (maj_point) begin
                    ferr_next = frame_ferr;
                    if (bit_cnt_reg == LAST_STOP) begin
                        frame_done = 1'b1;
                        state_next = frame_ferr ? WAIT_IDLE : IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            default: state_next = WAIT_IDLE;
        endcase
    end

    assign load = frame_done && (!dout_valid_reg || dout_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            perr_out_reg   <= 1'b0;
            ferr_out_reg   <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            overrun_reg <= frame_done && !load;
            if (load) begin
                dout_reg       <= shift_reg;
                perr_out_reg   <= perr_reg;
                ferr_out_reg   <= frame_ferr;
                dout_valid_reg <= 1'b1;
            end else if (dout_valid_reg && dout_ready) begin
                dout_valid_reg <= 1'b0;
            end
        end
    end

    assign dout        = dout_reg;
    assign dout_valid  = dout_valid_reg;
    assign parity_err  = perr_out_reg;
    assign framing_err = ferr_out_reg;
    assign overrun     = overrun_reg;
    // Gated by reset so every output reads 0 while rst_n is held low.
    assign busy        = rst_n && (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (8O1, 8E1, 7N2) driven from serial frames built
// by a bit-level model; received words are collected by a monitor and compared per scenario.
module tb_uart_rx_param;

    localparam int CLK_F   = 3_200_000;
    localparam int BAUD    = 100_000;
    localparam int BIT_CYC = CLK_F / BAUD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx_line = 3'b111;
    logic [2:0] rdy = 3'b111;
    logic [7:0] dout0, dout1;
    logic [6:0] dout2;
    logic [2:0] dv, perr, ferr, ovr, busy;

    int checks = 0;
    int errors = 0;
    logic [10:0] wq0[$], wq1[$], wq2[$];
    int vcyc[3];
    int ovr_cnt[3];

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQUENCY(CLK_F), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_line[0]), .dout(dout0), .dout_valid(dv[0]), .dout_ready(rdy[0]),
        .parity_err(perr[0]), .framing_err(ferr[0]), .overrun(ovr[0]), .busy(busy[0]));
    uart_rx_param #(.CLK_FREQUENCY(CLK_F), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_line[1]), .dout(dout1), .dout_valid(dv[1]), .dout_ready(rdy[1]),
        .parity_err(perr[1]), .framing_err(ferr[1]), .overrun(ovr[1]), .busy(busy[1]));
    uart_rx_param #(.CLK_FREQUENCY(CLK_F), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_line[2]), .dout(dout2), .dout_valid(dv[2]), .dout_ready(rdy[2]),
        .parity_err(perr[2]), .framing_err(ferr[2]), .overrun(ovr[2]), .busy(busy[2]));

    always @(negedge clk) begin
        if (dv[0] && rdy[0]) wq0.push_back({ferr[0], perr[0], 1'b0, dout0});
        if (dv[1] && rdy[1]) wq1.push_back({ferr[1], perr[1], 1'b0, dout1});
        if (dv[2] && rdy[2]) wq2.push_back({ferr[2], perr[2], 2'b00, dout2});
        for (int i = 0; i < 3; i++) begin
            if (dv[i]) vcyc[i]++;
            if (ovr[i]) ovr_cnt[i]++;
        end
    end

    function automatic int dbits_of(input int idx);
        return (idx == 2) ? 7 : 8;
    endfunction
    function automatic int pmode_of(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 2 : 0);
    endfunction
    function automatic int stops_of(input int idx);
        return (idx == 2) ? 2 : 1;
    endfunction

    // Correct parity bit for the word: odd mode makes the total ones count odd.
    function automatic bit par_bit(input int idx, input int data);
        int ones = 0;
        for (int i = 0; i < dbits_of(idx); i++) ones += (data >> i) & 1;
        return (pmode_of(idx) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    function automatic int qsize(input int idx);
        return (idx == 0) ? wq0.size() : ((idx == 1) ? wq1.size() : wq2.size());
    endfunction
    function automatic logic [10:0] qpop(input int idx);
        if (idx == 0) return wq0.pop_front();
        if (idx == 1) return wq1.pop_front();
        return wq2.pop_front();
    endfunction

    task automatic send_frame(input int idx, input int data, input bit flip_par, input int stop_low,
                              input bit pulses, input int hold_low);
        bit bits[$];
        bit is_data[$];
        int pulse_at;
        bits.push_back(1'b0); is_data.push_back(1'b0);
        for (int i = 0; i < dbits_of(idx); i++) begin
            bits.push_back(((data >> i) & 1) != 0); is_data.push_back(1'b1);
        end
        if (pmode_of(idx) != 0) begin
            bits.push_back(par_bit(idx, data) ^ flip_par); is_data.push_back(1'b0);
        end
        for (int s = 0; s < stops_of(idx); s++) begin
            bits.push_back(((stop_low >> s) & 1) == 0); is_data.push_back(1'b0);
        end
        foreach (bits[k]) begin
            pulse_at = (pulses && is_data[k] && !bits[k]) ? int'($urandom_range(12, 24)) : -1;
            for (int c = 0; c < BIT_CYC; c++) begin
                @(negedge clk);
                rx_line[idx] = (c == pulse_at) ? 1'b1 : bits[k];
            end
        end
        for (int c = 0; c < hold_low * BIT_CYC; c++) begin
            @(negedge clk);
            rx_line[idx] = 1'b0;
        end
        @(negedge clk);
        rx_line[idx] = 1'b1;
    endtask

    task automatic wait_word(input int idx, output logic [10:0] got, output bit found);
        found = 1'b0;
        got = '0;
        for (int t = 0; t < 2 * BIT_CYC; t++) begin
            if (qsize(idx) > 0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (found) got = qpop(idx);
    endtask

    task automatic set_ready(input int idx, input logic val);
        @(posedge clk);
        #1 rdy[idx] = val;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({dv, perr, ferr, ovr, busy} !== 15'd0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0", {dv, perr, ferr, ovr, busy});
        end
        checks++;
        if ({dout0, dout1, dout2} !== 23'd0) begin
            errors++;
            $display("FAIL reset_dout: got %h required 0", {dout0, dout1, dout2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b required 000", busy);
        end
    endtask

    task automatic test_basic;
        logic [10:0] got;
        bit found;
        vcyc[0] = 0;
        send_frame(0, 'hA5, 1'b0, 0, 1'b0, 0);
        wait_word(0, got, found);
        checks++;
        if (!found || got !== 11'h0A5) begin
            errors++;
            $display("FAIL basic_word: got %h found %0d required %h", got, found, 11'h0A5);
        end
        checks++;
        if (vcyc[0] != 1) begin
            errors++;
            $display("FAIL basic_valid_cycles: got %0d required 1", vcyc[0]);
        end
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: got %b required 0", busy[0]);
        end
    endtask

    task automatic test_parity;
        logic [10:0] got;
        bit found;
        send_frame(0, 'h3C, 1'b1, 0, 1'b0, 0);
        wait_word(0, got, found);
        checks++;
        if (!found || got !== {2'b01, 9'h03C}) begin
            errors++;
            $display("FAIL parity_odd_bad: got %h found %0d required %h", got, found, {2'b01, 9'h03C});
        end
        send_frame(1, 'h3C, 1'b0, 0, 1'b0, 0);
        wait_word(1, got, found);
        checks++;
        if (!found || got !== 11'h03C) begin
            errors++;
            $display("FAIL parity_even_ok: got %h found %0d required %h", got, found, 11'h03C);
        end
        send_frame(1, 'h3D, 1'b1, 0, 1'b0, 0);
        wait_word(1, got, found);
        checks++;
        if (!found || got !== {2'b01, 9'h03D}) begin
            errors++;
            $display("FAIL parity_even_bad: got %h found %0d required %h", got, found, {2'b01, 9'h03D});
        end
    endtask

    task automatic test_random;
        logic [10:0] got, exp;
        bit found, flip;
        int idx, data;
        for (int n = 0; n < 8; n++) begin
            idx = n % 2;
            data = int'($urandom_range(0, 255));
            flip = 1'($urandom_range(0, 1));
            send_frame(idx, data, flip, 0, 1'b1, 0);
            exp = {1'b0, flip, 9'(data)};
            wait_word(idx, got, found);
            checks++;
            if (!found || got !== exp) begin
                errors++;
                $display("FAIL random_%0d dut%0d: got %h found %0d required %h", n, idx, got, found, exp);
            end
        end
    endtask

    task automatic test_framing;
        logic [10:0] got;
        bit found;
        send_frame(0, 'h55, 1'b0, 1, 1'b0, 3);
        wait_word(0, got, found);
        checks++;
        if (!found || got !== {2'b10, 9'h055}) begin
            errors++;
            $display("FAIL framing_word: got %h found %0d required %h", got, found, {2'b10, 9'h055});
        end
        repeat (2 * BIT_CYC) @(negedge clk);
        checks++;
        if (wq0.size() != 0) begin
            errors++;
            $display("FAIL framing_no_extra: got %0d words required 0", wq0.size());
        end
        send_frame(0, 'h12, 1'b0, 0, 1'b0, 0);
        wait_word(0, got, found);
        checks++;
        if (!found || got !== 11'h012) begin
            errors++;
            $display("FAIL framing_recover: got %h found %0d required %h", got, found, 11'h012);
        end
    endtask

    task automatic test_glitch;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rx_line[0] = 1'b0;
        end
        @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
        checks++;
        if (wq0.size() != 0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject: got %0d words busy %b required 0 words busy 0", wq0.size(), busy[0]);
        end
    endtask

    task automatic test_overrun;
        logic [10:0] got;
        bit found;
        set_ready(0, 1'b0);
        ovr_cnt[0] = 0;
        send_frame(0, 'h11, 1'b0, 0, 1'b0, 0);
        checks++;
        if (dv[0] !== 1'b1 || dout0 !== 8'h11) begin
            errors++;
            $display("FAIL overrun_first: got valid %b dout %h required valid 1 dout 11", dv[0], dout0);
        end
        send_frame(0, 'h22, 1'b0, 0, 1'b0, 0);
        checks++;
        if (ovr_cnt[0] != 1 || dout0 !== 8'h11 || dv[0] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: got pulses %0d dout %h valid %b required 1 11 1", ovr_cnt[0], dout0, dv[0]);
        end
        set_ready(0, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (dv[0] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_drain_valid: got %b required 0", dv[0]);
        end
        wait_word(0, got, found);
        checks++;
        if (!found || got !== 11'h011) begin
            errors++;
            $display("FAIL overrun_drain_word: got %h found %0d required %h", got, found, 11'h011);
        end
        send_frame(0, 'h33, 1'b0, 0, 1'b0, 0);
        wait_word(0, got, found);
        checks++;
        if (!found || got !== 11'h033) begin
            errors++;
            $display("FAIL overrun_next: got %h found %0d required %h", got, found, 11'h033);
        end
    endtask

    task automatic test_two_stop;
        logic [10:0] got;
        bit found;
        send_frame(2, 'h5A, 1'b0, 0, 1'b0, 0);
        wait_word(2, got, found);
        checks++;
        if (!found || got !== 11'h05A) begin
            errors++;
            $display("FAIL two_stop_word: got %h found %0d required %h", got, found, 11'h05A);
        end
        send_frame(2, 'h2B, 1'b0, 2, 1'b0, 0);
        wait_word(2, got, found);
        checks++;
        if (!found || got !== {2'b10, 9'h02B}) begin
            errors++;
            $display("FAIL two_stop_ferr: got %h found %0d required %h", got, found, {2'b10, 9'h02B});
        end
    endtask

    task automatic test_reset_mid;
        set_ready(2, 1'b0);
        send_frame(2, 'h4D, 1'b0, 2, 1'b0, 0);
        checks++;
        if (dv[2] !== 1'b1 || dout2 !== 7'h4D || ferr[2] !== 1'b1) begin
            errors++;
            $display("FAIL held_word: got valid %b dout %h ferr %b required 1 4d 1", dv[2], dout2, ferr[2]);
        end
        for (int c = 0; c < 3 * BIT_CYC; c++) begin
            @(negedge clk);
            rx_line[2] = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dv !== 3'b000 || dout2 !== 7'h00 || ferr[2] !== 1'b0 || perr[2] !== 1'b0 || busy !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_outputs: got valid %b dout %h ferr %b busy %b required all 0", dv, dout2, ferr[2], busy);
        end
        @(negedge clk);
        rx_line[2] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        set_ready(2, 1'b1);
        repeat (3 * BIT_CYC) @(negedge clk);
        checks++;
        if (wq2.size() != 0 || dv[2] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_discard: got %0d words valid %b required 0 0", wq2.size(), dv[2]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_random;
        test_framing;
        test_glitch;
        test_overrun;
        test_two_stop;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
